zmaps_mf: RTL and testbench

- Parametrised successor of the Z80-to-EAB write mapper.
- Decodes Z80 memory writes in the FPGA-mapped window into NFILES on-chip RAM files, assembling BYTES-wide words from byte writes.
- Arbitrates against DMA: DMA has priority; CPU words are queued in a small pending FIFO instead of being dropped or overridden.
- Sits between the Z80 bus strobes and the FPRAM (CRAM, SFYS, ...) write ports.

---
 rtl/zmaps_pkg.sv | 18 +
 rtl/zmaps_if.sv | 38 +++
 rtl/zmaps_fifo.sv | 58 +++++
 rtl/zmaps_mf.sv | 191 +++++++++++++++++++
 tb/tb_zmaps_mf.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/zmaps_pkg.sv
// Shared definitions for the Z80-to-FPRAM write mapper: file indices and
// the lane-count helper used to size word addresses.
package zmaps_pkg;

  localparam int FILE_CRAM = 0;
  localparam int FILE_SFYS = 1;
  localparam int FILE_BITS = 3;

  function automatic int zmaps_log2(input int bytes);
    if (bytes >= 4)
      return 2;
    else if (bytes >= 2)
      return 1;
    else
      return 0;
  endfunction

endpackage

// File: rtl/zmaps_if.sv
// Bus bundle between the Z80/DMA side (master) and the write mapper (slave),
// including the FPRAM write-port outputs and status flags.
interface zmaps_if
  import zmaps_pkg::*;
#(
  parameter int NFILES = 2,
  parameter int BYTES  = 2
);

  localparam int AW = 9 - zmaps_log2(BYTES);
  localparam int DW = 8 * BYTES;

  logic              memwr_s;
  logic [15:0]       a;
  logic [7:0]        d;
  logic [4:0]        fmaddr;
  logic [DW-1:0]     dma_data;
  logic [AW-1:0]     dma_wraddr;
  logic [NFILES-1:0] dma_we;
  logic              ovf_clr;
  logic [DW-1:0]     zmd;
  logic [AW-1:0]     zma;
  logic [NFILES-1:0] we;
  logic              busy;
  logic              ovf;
  logic              lane_err;

  modport master (
    output memwr_s, a, d, fmaddr, dma_data, dma_wraddr, dma_we, ovf_clr,
    input  zmd, zma, we, busy, ovf, lane_err
  );

  modport slave (
    input  memwr_s, a, d, fmaddr, dma_data, dma_wraddr, dma_we, ovf_clr,
    output zmd, zma, we, busy, ovf, lane_err
  );

endinterface

// File: rtl/zmaps_fifo.sv
// Small synchronous FIFO holding CPU words while DMA owns the write port.
// A push and a pop in the same cycle are accepted even when full.
module zmaps_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/zmaps_mf.sv
// Z80-to-FPRAM write mapper: assembles byte writes into file words and
// arbitrates against DMA. Define ZMAPS_LANE_CHECK_EN to reject incomplete words.
module zmaps_mf
  import zmaps_pkg::*;
#(
  parameter int NFILES = 2,
  parameter int BYTES  = 2,
  parameter int DEPTH  = 4
) (
  input  logic   clk,
  input  logic   rst,
  zmaps_if.slave bus
);

  localparam int LB = zmaps_log2(BYTES);
  localparam int AW = 9 - LB;
  localparam int DW = 8 * BYTES;
  localparam int LW = (LB == 0) ? 1 : LB;
  localparam logic [LW-1:0] LAST_LANE = LW'(BYTES - 1);

  typedef struct packed {
    logic [FILE_BITS-1:0] file;
    logic [AW-1:0]        addr;
    logic [DW-1:0]        data;
  } zmaps_entry_t;

  localparam int EW = $bits(zmaps_entry_t);

  logic                 hit;
  logic                 final_lane;
  logic                 push_req;
  logic                 lane_bad;
  logic [LW-1:0]        lane;
  logic [AW-1:0]        waddr;
  logic [FILE_BITS-1:0] hit_file;
  logic [DW-1:0]        word;
  logic [7:0]           shadow [BYTES];

  logic                 dma_act;
  logic                 bypass;
  logic                 drop;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  zmaps_entry_t         push_entry;
  zmaps_entry_t         head;

  logic [NFILES-1:0]    we_q;
  logic [AW-1:0]        zma_q;
  logic [DW-1:0]        zmd_q;
  logic                 ovf_q;

  function automatic logic [NFILES-1:0] file_onehot(input logic [FILE_BITS-1:0] f);
    logic [NFILES-1:0] r;
    for (int i = 0; i < NFILES; i++)
      r[i] = (f == FILE_BITS'(i));
    return r;
  endfunction

  generate
    if (LB == 0) begin : g_nolane
      assign lane = '0;
    end else begin : g_lane
      assign lane = bus.a[LB-1:0];
    end
  endgenerate

  assign waddr      = bus.a[8:LB];
  assign hit_file   = bus.a[11:9];
  assign hit        = bus.memwr_s & bus.fmaddr[4] & (bus.a[15:12] == bus.fmaddr[3:0])
                    & ({1'b0, hit_file} < 4'(NFILES));
  assign final_lane = hit & (lane == LAST_LANE);

  // The incoming byte always lands in the top lane; lower lanes come from shadow.
  always_comb begin
    word = '0;
    for (int i = 0; i < BYTES - 1; i++)
      word[8*i +: 8] = shadow[i];
    word[DW-1 -: 8] = bus.d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BYTES; i++)
        shadow[i] <= '0;
    end else if (hit && lane != LAST_LANE) begin
      shadow[lane] <= bus.d;
    end
  end

`ifdef ZMAPS_LANE_CHECK_EN
  localparam logic [BYTES-1:0] LOW_MASK = (BYTES'(1) << (BYTES - 1)) - BYTES'(1);

  logic [BYTES-1:0] valid;
  logic             all_low_valid;
  logic             lane_err_q;

  assign all_low_valid = ((valid & LOW_MASK) == LOW_MASK);
  assign push_req      = final_lane & all_low_valid;
  assign lane_bad      = final_lane & ~all_low_valid;

  always_ff @(posedge clk) begin
    if (rst)
      valid <= '0;
    else if (final_lane)
      valid <= '0;
    else if (hit)
      valid[lane] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      lane_err_q <= 1'b0;
    else if (lane_bad)
      lane_err_q <= 1'b1;
    else if (bus.ovf_clr)
      lane_err_q <= 1'b0;
  end

  assign bus.lane_err = lane_err_q;
`else
  assign push_req     = final_lane;
  assign lane_bad     = 1'b0;
  assign bus.lane_err = lane_bad;
`endif

  assign push_entry = '{file: hit_file, addr: waddr, data: word};

  // A fresh word skips the queue only when nothing older is waiting.
  assign dma_act   = |bus.dma_we;
  assign fifo_pop  = ~dma_act & ~fifo_empty;
  assign bypass    = ~dma_act & fifo_empty & push_req;
  assign fifo_push = push_req & ~bypass & (~fifo_full | fifo_pop);
  assign drop      = push_req & fifo_full & ~fifo_pop;

  zmaps_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q  <= '0;
      zma_q <= '0;
      zmd_q <= '0;
    end else if (dma_act) begin
      we_q  <= bus.dma_we;
      zma_q <= bus.dma_wraddr;
      zmd_q <= bus.dma_data;
    end else if (!fifo_empty) begin
      we_q  <= file_onehot(head.file);
      zma_q <= head.addr;
      zmd_q <= head.data;
    end else if (push_req) begin
      we_q  <= file_onehot(push_entry.file);
      zma_q <= push_entry.addr;
      zmd_q <= push_entry.data;
    end else begin
      we_q  <= '0;
    end
  end

  // Set beats clear so a drop in the same cycle as ovf_clr is never lost.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (drop)
      ovf_q <= 1'b1;
    else if (bus.ovf_clr)
      ovf_q <= 1'b0;
  end

  assign bus.we   = we_q;
  assign bus.zma  = zma_q;
  assign bus.zmd  = zmd_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (fifo_count != '0);

endmodule

// File: tb/tb_zmaps_mf.sv
// Directed bench for zmaps_mf (NFILES=2, BYTES=2, DEPTH=4) with hand-computed
// expectations; inputs change 1 time unit after the rising edge.
module tb_zmaps_mf;
  import zmaps_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  zmaps_if #(.NFILES(2), .BYTES(2)) bus ();

  zmaps_mf #(
    .NFILES (2),
    .BYTES  (2),
    .DEPTH  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] WE_CRAM = 2'(1 << FILE_CRAM);
  localparam logic [1:0] WE_SFYS = 2'(1 << FILE_SFYS);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkCommit(input string tag, input logic [1:0] we_e,
                             input logic [7:0] zma_e, input logic [15:0] zmd_e);
    checkOutput({tag, " we"}, 32'(bus.we), 32'(we_e));
    checkOutput({tag, " zma"}, 32'(bus.zma), 32'(zma_e));
    checkOutput({tag, " zmd"}, 32'(bus.zmd), 32'(zmd_e));
  endtask

  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [7:0] data);
    bus.memwr_s = wr;
    bus.a       = addr;
    bus.d       = data;
    @(posedge clk);
    #1;
    bus.memwr_s = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 16'h0000, 8'h00);
  endtask

  // Word k: file k&1, word address k+1, bytes {A0+k, 10+k}.
  function automatic logic [15:0] wordAddr(input int k);
    return 16'hF000 | (16'(k & 1) << 9) | (16'(k + 1) << 1);
  endfunction

  function automatic logic [15:0] wordData(input int k);
    return {8'(8'hA0 + k), 8'(8'h10 + k)};
  endfunction

  task automatic pushWord(input int k, input logic clr_on_final);
    applyStimulus(1'b1, wordAddr(k), 8'(8'h10 + k));
    bus.ovf_clr = clr_on_final;
    applyStimulus(1'b1, wordAddr(k) | 16'h0001, 8'(8'hA0 + k));
    bus.ovf_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.memwr_s    = 1'b0;
    bus.a          = '0;
    bus.d          = '0;
    bus.fmaddr     = 5'h1F;
    bus.dma_data   = '0;
    bus.dma_wraddr = '0;
    bus.dma_we     = '0;
    bus.ovf_clr    = 1'b0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset we", 32'(bus.we), 32'h0);
    checkOutput("reset zma", 32'(bus.zma), 32'h0);
    checkOutput("reset zmd", 32'(bus.zmd), 32'h0);
    checkOutput("reset busy", 32'(bus.busy), 32'h0);
    checkOutput("reset ovf", 32'(bus.ovf), 32'h0);
    checkOutput("reset lane_err", 32'(bus.lane_err), 32'h0);
    rst = 1'b0;

    $display("[TB] idle CPU write");
    applyStimulus(1'b1, 16'hF000, 8'h34);
    checkOutput("idle low byte we", 32'(bus.we), 32'h0);
    applyStimulus(1'b1, 16'hF001, 8'h12);
    checkCommit("idle commit", WE_CRAM, 8'h00, 16'h1234);
    checkOutput("idle busy", 32'(bus.busy), 32'h0);
    idleCycle();
    checkOutput("idle after we", 32'(bus.we), 32'h0);
    checkOutput("idle zmd hold", 32'(bus.zmd), 32'h1234);

    $display("[TB] DMA priority");
    applyStimulus(1'b1, 16'hF200, 8'hAB);
    checkOutput("dma low byte we", 32'(bus.we), 32'h0);
    bus.dma_we = 2'b01; bus.dma_wraddr = 8'h10; bus.dma_data = 16'h1111;
    applyStimulus(1'b1, 16'hF201, 8'hCD);
    checkCommit("dma cycle1", 2'b01, 8'h10, 16'h1111);
    checkOutput("dma busy1", 32'(bus.busy), 32'h1);
    bus.dma_wraddr = 8'h11; bus.dma_data = 16'h2222;
    idleCycle();
    checkCommit("dma cycle2", 2'b01, 8'h11, 16'h2222);
    checkOutput("dma busy2", 32'(bus.busy), 32'h1);
    bus.dma_wraddr = 8'h12; bus.dma_data = 16'h3333;
    idleCycle();
    checkCommit("dma cycle3", 2'b01, 8'h12, 16'h3333);
    checkOutput("dma busy3", 32'(bus.busy), 32'h1);
    bus.dma_we = 2'b00;
    idleCycle();
    checkCommit("dma queued cpu", WE_SFYS, 8'h00, 16'hCDAB);
    checkOutput("dma busy after", 32'(bus.busy), 32'h0);
    idleCycle();
    checkOutput("dma idle we", 32'(bus.we), 32'h0);

    $display("[TB] overflow");
    bus.dma_we = 2'b01; bus.dma_wraddr = 8'h20; bus.dma_data = 16'h5555;
    for (int k = 0; k < 5; k++) begin
      pushWord(k, k == 4);
      if (k == 3)
        checkOutput("ovf before drop", 32'(bus.ovf), 32'h0);
    end
    checkCommit("ovf dma hold", 2'b01, 8'h20, 16'h5555);
    checkOutput("ovf busy", 32'(bus.busy), 32'h1);
    checkOutput("ovf set over clr", 32'(bus.ovf), 32'h1);
    applyStimulus(1'b1, wordAddr(6), 8'h16);
    bus.dma_we = 2'b00;
    applyStimulus(1'b1, wordAddr(6) | 16'h0001, 8'hA6);
    for (int j = 0; j < 5; j++) begin
      int k;
      k = (j < 4) ? j : 6;
      if (j > 0)
        idleCycle();
      checkCommit($sformatf("ovf drain%0d", j), 2'(1 << (k & 1)), 8'(k + 1), wordData(k));
    end
    checkOutput("ovf sticky", 32'(bus.ovf), 32'h1);
    idleCycle();
    checkOutput("ovf drained we", 32'(bus.we), 32'h0);
    checkOutput("ovf drained busy", 32'(bus.busy), 32'h0);
    bus.ovf_clr = 1'b1;
    idleCycle();
    bus.ovf_clr = 1'b0;
    checkOutput("ovf cleared", 32'(bus.ovf), 32'h0);

    $display("[TB] decode misses");
    applyStimulus(1'b1, 16'hF000, 8'h55);
    bus.fmaddr = 5'h0F;
    applyStimulus(1'b1, 16'hF000, 8'hEE);
    checkOutput("miss window lo", 32'(bus.we), 32'h0);
    applyStimulus(1'b1, 16'hF001, 8'hEE);
    checkOutput("miss window hi", 32'(bus.we), 32'h0);
    bus.fmaddr = 5'h1F;
    applyStimulus(1'b1, 16'hE000, 8'hEE);
    checkOutput("miss page lo", 32'(bus.we), 32'h0);
    applyStimulus(1'b1, 16'hE001, 8'hEE);
    checkOutput("miss page hi", 32'(bus.we), 32'h0);
    applyStimulus(1'b1, 16'hF600, 8'hEE);
    checkOutput("miss file lo", 32'(bus.we), 32'h0);
    applyStimulus(1'b1, 16'hF601, 8'hEE);
    checkOutput("miss file hi", 32'(bus.we), 32'h0);
    checkOutput("miss busy", 32'(bus.busy), 32'h0);
    applyStimulus(1'b1, 16'hF001, 8'h66);
    checkCommit("miss shadow intact", WE_CRAM, 8'h00, 16'h6655);

    $display("[TB] reset mid-queue");
    bus.dma_we = 2'b10; bus.dma_wraddr = 8'h30; bus.dma_data = 16'h7777;
    for (int k = 0; k < 5; k++)
      pushWord(k, 1'b0);
    checkOutput("rstq busy before", 32'(bus.busy), 32'h1);
    checkOutput("rstq ovf before", 32'(bus.ovf), 32'h1);
    bus.dma_we = 2'b00;
    rst = 1'b1;
    idleCycle();
    rst = 1'b0;
    checkOutput("rstq we", 32'(bus.we), 32'h0);
    checkOutput("rstq busy", 32'(bus.busy), 32'h0);
    checkOutput("rstq ovf", 32'(bus.ovf), 32'h0);
    applyStimulus(1'b1, 16'hF000, 8'h42);
    checkOutput("rstq low byte we", 32'(bus.we), 32'h0);
    applyStimulus(1'b1, 16'hF001, 8'h43);
    checkCommit("rstq commit", WE_CRAM, 8'h00, 16'h4342);
    idleCycle();
    checkOutput("rstq no stale we", 32'(bus.we), 32'h0);
    checkOutput("rstq no stale busy", 32'(bus.busy), 32'h0);

    $display("[TB] lane check");
    applyStimulus(1'b1, 16'hF003, 8'h99);
`ifdef ZMAPS_LANE_CHECK_EN
    checkOutput("lane reject we", 32'(bus.we), 32'h0);
    checkOutput("lane_err set", 32'(bus.lane_err), 32'h1);
    checkOutput("lane busy", 32'(bus.busy), 32'h0);
    bus.ovf_clr = 1'b1;
    idleCycle();
    bus.ovf_clr = 1'b0;
    checkOutput("lane_err cleared", 32'(bus.lane_err), 32'h0);
`else
    checkCommit("lane stale commit", WE_CRAM, 8'h01, 16'h9942);
    checkOutput("lane_err tied", 32'(bus.lane_err), 32'h0);
`endif
    idleCycle();
    checkOutput("final we", 32'(bus.we), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
